// File: rtl/multi_osc_ctrl.sv
// multi_osc_ctrl: variable-step time base for NUM_OSC emulated oscillators.
// Each step advances emulated time to the nearest pending oscillator edge,
// toggles every channel whose edge lands there, and counts rising edges
// until all channels have produced N_CYCLES of them.
module multi_osc_ctrl #(
  parameter int NUM_OSC   = 2,
  parameter int DT_WIDTH  = 32,
  parameter int CNT_WIDTH = 16,
  parameter int N_CYCLES  = 10,
  localparam int CHW      = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [CHW-1:0]                 cfg_chan,
  input  logic                           cfg_sel,
  input  logic [DT_WIDTH-1:0]            cfg_data,
  input  logic                           run,
  output logic [DT_WIDTH-1:0]            dt_out,
  output logic                           dt_valid,
  output logic [63:0]                    t_emu,
  output logic [NUM_OSC-1:0]             osc_clk,
  output logic [NUM_OSC*CNT_WIDTH-1:0]   cycle_cnt,
  output logic [NUM_OSC-1:0]             done,
  output logic                           all_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] NCYC = CNT_WIDTH'(N_CYCLES);

  state_t                state_q;
  logic                  cfg_ready_q;
  logic                  dt_valid_q;
  logic                  all_done_q;
  logic [DT_WIDTH-1:0]   dt_q;
  logic [63:0]           t_emu_q;
  logic [DT_WIDTH-1:0]   t_lo_q  [NUM_OSC];
  logic [DT_WIDTH-1:0]   t_hi_q  [NUM_OSC];
  logic [DT_WIDTH-1:0]   rem_q   [NUM_OSC];
  logic [CNT_WIDTH-1:0]  cnt_q   [NUM_OSC];
  logic [NUM_OSC-1:0]    phase_q;
  logic [NUM_OSC-1:0]    done_q;

  logic [DT_WIDTH-1:0]   dt_d;
  logic [DT_WIDTH-1:0]   rem_d   [NUM_OSC];
  logic [CNT_WIDTH-1:0]  cnt_d   [NUM_OSC];
  logic [NUM_OSC-1:0]    phase_d;
  logic [NUM_OSC-1:0]    done_d;

  // A zero half-period would stall the time base, so it is promoted to 1.
  function automatic logic [DT_WIDTH-1:0] nz_period(input logic [DT_WIDTH-1:0] v);
    return (v == '0) ? DT_WIDTH'(1) : v;
  endfunction

  // Rising-edge counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Step size: time remaining until the earliest pending edge
  always_comb begin
    dt_d = rem_q[0];
    for (int i = 1; i < NUM_OSC; i++) begin
      if (rem_q[i] < dt_d) dt_d = rem_q[i];
    end
  end

  // Per-channel next state for one step; all channels hitting dt toggle together
  always_comb begin
    phase_d = phase_q;
    done_d  = done_q;
    for (int i = 0; i < NUM_OSC; i++) begin
      rem_d[i] = rem_q[i] - dt_d;
      cnt_d[i] = cnt_q[i];
      if (rem_q[i] == dt_d) begin
        phase_d[i] = ~phase_q[i];
        if (phase_q[i]) begin
          rem_d[i] = t_lo_q[i];
        end else begin
          rem_d[i] = t_hi_q[i];
          cnt_d[i] = sat_inc(cnt_q[i]);
          if (sat_inc(cnt_q[i]) == NCYC) done_d[i] = 1'b1;
        end
      end
    end
  end

  // Control FSM plus all registered state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cfg_ready_q <= 1'b1;
      dt_q        <= '0;
      dt_valid_q  <= 1'b0;
      t_emu_q     <= '0;
      phase_q     <= '0;
      done_q      <= '0;
      all_done_q  <= 1'b0;
      for (int i = 0; i < NUM_OSC; i++) begin
        t_lo_q[i] <= DT_WIDTH'(1);
        t_hi_q[i] <= DT_WIDTH'(1);
        rem_q[i]  <= DT_WIDTH'(1);
        cnt_q[i]  <= '0;
      end
    end else begin
      dt_valid_q <= 1'b0;
      // cfg_ready_q is high exactly in IDLE and DONE; out-of-range channels match nothing
      if (cfg_valid && cfg_ready_q) begin
        for (int i = 0; i < NUM_OSC; i++) begin
          if (cfg_chan == CHW'(i)) begin
            if (cfg_sel) t_hi_q[i] <= nz_period(cfg_data);
            else         t_lo_q[i] <= nz_period(cfg_data);
          end
        end
      end
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q     <= S_LOAD;
            cfg_ready_q <= 1'b0;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < NUM_OSC; i++) begin
            rem_q[i] <= t_lo_q[i];
            cnt_q[i] <= '0;
          end
          phase_q    <= '0;
          done_q     <= '0;
          all_done_q <= 1'b0;
          t_emu_q    <= '0;
          state_q    <= S_RUN;
        end
        S_RUN: begin
          if (run) begin
            for (int i = 0; i < NUM_OSC; i++) begin
              rem_q[i] <= rem_d[i];
              cnt_q[i] <= cnt_d[i];
            end
            phase_q    <= phase_d;
            done_q     <= done_d;
            all_done_q <= &done_d;
            dt_q       <= dt_d;
            dt_valid_q <= 1'b1;
            t_emu_q    <= t_emu_q + 64'(dt_d);
            if (&done_d) begin
              state_q     <= S_DONE;
              cfg_ready_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!run) state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Flatten per-channel counters onto the packed output bus
  always_comb begin
    cycle_cnt = '0;
    for (int i = 0; i < NUM_OSC; i++) begin
      cycle_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign dt_out    = dt_q;
  assign dt_valid  = dt_valid_q;
  assign t_emu     = t_emu_q;
  assign osc_clk   = phase_q;
  assign done      = done_q;
  assign all_done  = all_done_q;

endmodule
